// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy state encoding, per-boundary default widths, EX/MEM control bit positions.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } ps_state_e;

   // Default widths for each stage boundary
   localparam int IFID_CTRL_W  = 1;
   localparam int IFID_DATA_W  = 64;
   localparam int IDEX_CTRL_W  = 9;
   localparam int IDEX_DATA_W  = 146;
   localparam int EXMEM_CTRL_W = 6;
   localparam int EXMEM_DATA_W = 104;
   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 69;

   // EX/MEM control vector bit positions
   localparam int EXMEM_BRANCH    = 0;
   localparam int EXMEM_MEM_READ  = 1;
   localparam int EXMEM_MEM_TO_RG = 2;
   localparam int EXMEM_MEM_WRITE = 3;
   localparam int EXMEM_REG_WRITE = 4;
   localparam int EXMEM_ZERO_FLAG = 5;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall/bubble counter pair observing the output side of a pipeline stage.
module pipe_stage_perf #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] bubble_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (!out_valid && (bubble_cnt_reg != '1))
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_REG_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 6,
   parameter int DATA_W = 104
`ifdef PIPE_STAGE_REG_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_REG_PERF_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
`endif
   output logic [1:0]        occupancy
);

   ps_state_e         state_reg,     state_next;
   logic              main_vld_reg,  main_vld_next;
   logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
   logic [DATA_W-1:0] main_data_reg, main_data_next;
   logic              skid_vld_reg,  skid_vld_next;
   logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
   logic [DATA_W-1:0] skid_data_reg, skid_data_next;
   logic              acc;
   logic              dq;

   assign in_ready = (state_reg != PS_TWO);
   assign acc      = in_valid && in_ready;
   assign dq       = main_vld_reg && out_ready;

   always_comb begin
      state_next     = state_reg;
      main_vld_next  = main_vld_reg;
      main_ctrl_next = main_ctrl_reg;
      main_data_next = main_data_reg;
      skid_vld_next  = skid_vld_reg;
      skid_ctrl_next = skid_ctrl_reg;
      skid_data_next = skid_data_reg;
      if (flush) begin
         // Payload registers keep their contents; out_ctrl masking hides them.
         state_next    = PS_EMPTY;
         main_vld_next = 1'b0;
         skid_vld_next = 1'b0;
      end else begin
         case (state_reg)
            PS_EMPTY: begin
               if (acc) begin
                  state_next     = PS_ONE;
                  main_vld_next  = 1'b1;
                  main_ctrl_next = in_ctrl;
                  main_data_next = in_data;
               end
            end
            PS_ONE: begin
               if (acc && dq) begin
                  main_ctrl_next = in_ctrl;
                  main_data_next = in_data;
               end else if (acc) begin
                  state_next     = PS_TWO;
                  skid_vld_next  = 1'b1;
                  skid_ctrl_next = in_ctrl;
                  skid_data_next = in_data;
               end else if (dq) begin
                  state_next    = PS_EMPTY;
                  main_vld_next = 1'b0;
               end
            end
            PS_TWO: begin
               if (dq) begin
                  state_next     = PS_ONE;
                  main_ctrl_next = skid_ctrl_reg;
                  main_data_next = skid_data_reg;
                  skid_vld_next  = 1'b0;
               end
            end
            default: begin
               state_next    = PS_EMPTY;
               main_vld_next = 1'b0;
               skid_vld_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= PS_EMPTY;
         main_vld_reg  <= 1'b0;
         main_ctrl_reg <= '0;
         main_data_reg <= '0;
         skid_vld_reg  <= 1'b0;
         skid_ctrl_reg <= '0;
         skid_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         main_vld_reg  <= main_vld_next;
         main_ctrl_reg <= main_ctrl_next;
         main_data_reg <= main_data_next;
         skid_vld_reg  <= skid_vld_next;
         skid_ctrl_reg <= skid_ctrl_next;
         skid_data_reg <= skid_data_next;
      end
   end

   // Bubbles always present a zero control vector downstream
   for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl[gi] = main_ctrl_reg[gi] & main_vld_reg;
   end

   assign out_valid = main_vld_reg;
   assign out_data  = main_data_reg;
   assign occupancy = state_reg;

`ifdef PIPE_STAGE_REG_PERF_EN
   pipe_stage_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk        (clk),
      .rst_n      (rst_n),
      .out_valid  (main_vld_reg),
      .out_ready  (out_ready),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand sequences and an output scoreboard.
// Counter checks are included when PIPE_STAGE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

   localparam int CW = 6;
   localparam int DW = 104;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_REG_PERF_EN
   logic [3:0]    stall_cnt;
   logic [3:0]    bubble_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .CTRL_W (CW),
      .DATA_W (DW)
`ifdef PIPE_STAGE_REG_PERF_EN
      , .CNT_W (4)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
`ifdef PIPE_STAGE_REG_PERF_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
`endif
      .occupancy  (occupancy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
      else
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: words pushed on accept, popped when the downstream transfer happens
   typedef struct {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } word_t;

   word_t         sb_q[$];
   word_t         mon_w;
   logic          prev_stall = 1'b0;
   logic [CW-1:0] prev_ctrl;
   logic [DW-1:0] prev_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("occupancy_vs_model", occupancy, sb_q.size());
         if (!out_valid)
            check("bubble_ctrl_zero", out_ctrl, 0);
         if (prev_stall) begin
            check("hold_ctrl", out_ctrl, prev_ctrl);
            check("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got %0h, expected no word", out_data);
            end else begin
               mon_w = sb_q.pop_front();
               check("sb_ctrl", out_ctrl, mon_w.ctrl);
               check("sb_data", out_data, mon_w.data);
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev_ctrl  = out_ctrl;
         prev_data  = out_data;
         if (flush)
            sb_q.delete();
         else if (in_valid && in_ready)
            sb_q.push_back('{in_ctrl, in_data});
      end
   end

   typedef struct {
      logic          iv;
      logic          ordy;
      logic          fl;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [1:0]    e_occ;
      logic          e_ov;
      logic          e_ir;
   } vec_t;

   vec_t tbl[14];

   initial begin
      // iv  ordy fl  ctrl    data    occ   ov    ir
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'h01, 104'hA, 2'd1, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'h02, 104'hB, 2'd2, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'h03, 104'hC, 2'd2, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 6'h03, 104'hC, 2'd1, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 6'h03, 104'hC, 2'd1, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 6'h00, 104'h0, 2'd0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 6'h3F, 104'hD1, 2'd1, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 6'h3F, 104'hD2, 2'd2, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 6'h3F, 104'hD, 2'd0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 6'h00, 104'h0, 2'd0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 6'h15, 104'hE, 2'd1, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 6'h00, 104'h0, 2'd0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 6'h2A, 104'hF, 2'd1, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 6'h00, 104'h0, 2'd0, 1'b0, 1'b1};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 6'h3F;
      in_data   = 104'h55;
      out_ready = 1'b0;
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occupancy", occupancy, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      // Backpressure, flush in TWO, flush with transfer in ONE
      for (int i = 0; i < 14; i++) begin
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         in_ctrl   = tbl[i].c;
         in_data   = tbl[i].d;
         step();
         check($sformatf("vec%0d_occ", i), occupancy, tbl[i].e_occ);
         check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
         check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      end
      flush = 1'b0;

      // Full-rate streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_ctrl  = 6'h3F;
         in_data  = DW'(i);
         step();
         check("stream_in_ready", in_ready, 1);
         check("stream_out", {out_valid, out_ctrl, out_data}, {1'b1, 6'h3F, DW'(i)});
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", out_valid, 0);

      // Asynchronous reset while holding two entries
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 6'h11;
      in_data   = 104'h71;
      step();
      in_data = 104'h72;
      step();
      in_valid = 1'b0;
      check("pre_areset_occ", occupancy, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_out_valid", out_valid, 0);
      check("areset_out_ctrl", out_ctrl, 0);
      check("areset_out_data", out_data, 0);
      check("areset_in_ready", in_ready, 1);
      check("areset_occ", occupancy, 0);
      step();
      rst_n = 1'b1;
      step();

`ifdef PIPE_STAGE_REG_PERF_EN
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_ctrl  = 6'h09;
      in_data  = 104'h90;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      check("perf_stall_5", stall_cnt, 5);
      out_ready = 1'b1;
      step();
      repeat (3) step();
      check("perf_bubble_ge3", bubble_cnt >= 4'd3, 1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 104'h91;
      step();
      in_valid = 1'b0;
      repeat (20) step();
      check("perf_stall_sat", stall_cnt, 15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("perf_stall_after_flush", stall_cnt, 15);
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
